// File: rtl/register_file_sp_arb.sv
// Single-port regfile arbiter: one write and one read requester share the port.
// Define RF_ARB_WR_PRIO_EN for fixed write priority; default is round-robin on ties.
module register_file_sp_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  input  logic                  rd_rsp_ready,
  output logic                  rf_enable,
  output logic                  rf_wr,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  input  logic [DATA_WIDTH-1:0] rf_read_data
);

  logic                  wr_elig_s;
  logic                  rd_elig_s;
  logic                  pick_wr_s;
  logic                  rsp_valid_r;
  logic                  fresh_r;
  logic [DATA_WIDTH-1:0] hold_r;
`ifndef RF_ARB_WR_PRIO_EN
  logic                  last_wr_r;
`endif

  // Eligibility and arbitration; a read may only go when the response slot frees up.
  always_comb begin
    wr_elig_s = wr_req;
    rd_elig_s = rd_req & (~rsp_valid_r | rd_rsp_ready);
`ifdef RF_ARB_WR_PRIO_EN
    pick_wr_s = wr_elig_s;
`else
    if (wr_elig_s && rd_elig_s) begin
      pick_wr_s = ~last_wr_r;
    end else begin
      pick_wr_s = wr_elig_s;
    end
`endif
    if (resetn) begin
      wr_gnt = pick_wr_s;
      rd_gnt = rd_elig_s & ~pick_wr_s;
    end else begin
      wr_gnt = 1'b0;
      rd_gnt = 1'b0;
    end
  end

  // Regfile port drive.
  always_comb begin
    rf_enable     = wr_gnt | rd_gnt;
    rf_wr         = wr_gnt;
    rf_write_addr = wr_addr;
    rf_write_data = wr_data;
    rf_read_addr  = rd_addr;
  end

`ifndef RF_ARB_WR_PRIO_EN
  // Round-robin history; reset value makes the write win the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_wr_r <= 1'b0;
    end else if (wr_gnt) begin
      last_wr_r <= 1'b1;
    end else if (rd_gnt) begin
      last_wr_r <= 1'b0;
    end else begin
      last_wr_r <= last_wr_r;
    end
  end
`endif

  // Response slot: valid follows a grant, clears on accept without a new grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_r <= 1'b0;
      fresh_r     <= 1'b0;
      hold_r      <= {DATA_WIDTH{1'b0}};
    end else begin
      fresh_r <= rd_gnt;
      if (rd_gnt) begin
        rsp_valid_r <= 1'b1;
      end else if (rsp_valid_r && rd_rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end else begin
        rsp_valid_r <= rsp_valid_r;
      end
      if (fresh_r) begin
        hold_r <= rf_read_data;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

  // Fresh data comes straight from the regfile; afterwards the captured copy is held
  // so later regfile activity cannot disturb a stalled response.
  always_comb begin
    rd_rsp_valid = rsp_valid_r;
    if (fresh_r) begin
      rd_rsp_data = rf_read_data;
    end else begin
      rd_rsp_data = hold_r;
    end
  end

endmodule

// File: tb/tb_register_file_sp_arb.sv
// Directed bench for register_file_sp_arb with a behavioural regfile and a
// response scoreboard popped by an independent monitor.
module tb_register_file_sp_arb;
  logic       clk = 1'b0;
  logic       resetn;
  logic       wr_req, rd_req, rd_rsp_ready;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic       wr_gnt, rd_gnt, rd_rsp_valid;
  logic [7:0] rd_rsp_data;
  logic       rf_enable, rf_wr;
  logic [7:0] rf_write_addr, rf_read_addr, rf_write_data;
  logic [7:0] rf_read_data;
  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_file_sp_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .rd_rsp_ready(rd_rsp_ready),
    .rf_enable(rf_enable), .rf_wr(rf_wr),
    .rf_write_addr(rf_write_addr), .rf_read_addr(rf_read_addr),
    .rf_write_data(rf_write_data), .rf_read_data(rf_read_data)
  );

  // Behavioural single-port regfile with one-cycle read latency.
  always @(posedge clk) begin
    if (rf_enable) begin
      if (rf_wr) mem[rf_write_addr] <= rf_write_data;
      else       rf_read_data       <= mem[rf_read_addr];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted response must match the oldest expected value.
  always @(negedge clk) begin
    if (resetn && rd_rsp_valid && rd_rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got data %0h, required no response", rd_rsp_data);
      end else begin
        chk("rsp_data", int'(rd_rsp_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ew;
    resetn = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rd_rsp_ready = 1'b0;
    wr_addr = 8'h00; wr_data = 8'h00; rd_addr = 8'h00;
    #3;
    wr_req = 1'b1; rd_req = 1'b1;
    #1;
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_rf_enable", rf_enable, 0);
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_valid", rd_rsp_valid, 0);
    wr_req = 1'b0; rd_req = 1'b0;
    step(); step();
    resetn = 1'b1;

    // Write 0x05 = 0xA5, then read it back.
    step(); wr_req = 1'b1; wr_addr = 8'h05; wr_data = 8'hA5; #1;
    chk("w035_gnt", wr_gnt, 1);
    chk("w035_rd_gnt", rd_gnt, 0);
    chk("w035_en", rf_enable, 1);
    chk("w035_wr", rf_wr, 1);
    chk("w035_addr", rf_write_addr, 8'h05);
    chk("w035_data", rf_write_data, 8'hA5);
    step(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 8'h05; rd_rsp_ready = 1'b1; #1;
    chk("r035_gnt", rd_gnt, 1);
    chk("r035_wr", rf_wr, 0);
    chk("r035_addr", rf_read_addr, 8'h05);
    exp_q.push_back(8'hA5);
    step(); rd_req = 1'b0; #1;
    chk("r035_valid", rd_rsp_valid, 1);
    step(); #1;
    chk("r035_done", rd_rsp_valid, 0);

    // Both requesting continuously: alternation (or all writes with priority).
    step(); wr_req = 1'b1; wr_addr = 8'h30; wr_data = 8'h3C; rd_req = 1'b1; rd_addr = 8'h30;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      #1;
`ifdef RF_ARB_WR_PRIO_EN
      ew = 1'b1;
`else
      ew = (i % 2 == 0);
`endif
      chk("rr_wr_gnt", wr_gnt, int'(ew));
      chk("rr_rd_gnt", rd_gnt, int'(!ew));
      if (!ew) exp_q.push_back(8'h3C);
    end
    step(); wr_req = 1'b0; rd_req = 1'b0;
    step();

    // Stalled response; writes still proceed and do not disturb it.
    step(); wr_req = 1'b1; wr_addr = 8'h10; wr_data = 8'h5A; #1;
    chk("w037a_gnt", wr_gnt, 1);
    step(); wr_addr = 8'h11; wr_data = 8'h6B; #1;
    chk("w037b_gnt", wr_gnt, 1);
    step(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 8'h10; rd_rsp_ready = 1'b0; #1;
    chk("r037_gnt", rd_gnt, 1);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 3; i++) begin
      step(); rd_addr = 8'h11;
      wr_req = (i == 1); wr_addr = 8'h20; wr_data = 8'h77; #1;
      chk("stall_rd_gnt", rd_gnt, 0);
      chk("stall_valid", rd_rsp_valid, 1);
      chk("stall_data", rd_rsp_data, 8'h5A);
      if (i == 1) chk("stall_wr_gnt", wr_gnt, 1);
    end
    step(); wr_req = 1'b0; rd_rsp_ready = 1'b1; #1;
    chk("accept_rd_gnt", rd_gnt, 1);
    exp_q.push_back(8'h6B);
    step(); rd_req = 1'b0; #1;
    chk("b2b_valid", rd_rsp_valid, 1);
    step(); #1;
    chk("accept_done", rd_rsp_valid, 0);

    // Four back-to-back reads after filling 0x01..0x04.
    for (int k = 1; k <= 4; k++) begin
      step(); wr_req = 1'b1; wr_addr = 8'(k); wr_data = 8'(8'hC0 + k); #1;
      chk("fill_gnt", wr_gnt, 1);
    end
    for (int k = 1; k <= 4; k++) begin
      step(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 8'(k); #1;
      chk("seq_rd_gnt", rd_gnt, 1);
      if (k > 1) chk("seq_valid", rd_rsp_valid, 1);
      exp_q.push_back(8'(8'hC0 + k));
    end
    step(); rd_req = 1'b0; #1;
    chk("seq_valid_last", rd_rsp_valid, 1);
    step(); #1;
    chk("seq_done", rd_rsp_valid, 0);

    // Reset right after a read grant discards the response; contents survive.
    step(); rd_req = 1'b1; rd_addr = 8'h01; #1;
    chk("r039_gnt", rd_gnt, 1);
    step(); rd_req = 1'b0; resetn = 1'b0; #1;
    chk("r039_rst_valid", rd_rsp_valid, 0);
    step(); step(); resetn = 1'b1; #1;
    chk("r039_rel_valid", rd_rsp_valid, 0);
    step(); #1;
    chk("r039_rel_valid2", rd_rsp_valid, 0);
    step(); rd_req = 1'b1; rd_addr = 8'h04; #1;
    chk("r039_post_gnt", rd_gnt, 1);
    exp_q.push_back(8'hC4);
    step(); rd_req = 1'b0;
    step(); step(); #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
